// File: rtl/contador_updown_param.sv
// ============================================================================
// Module      : contador_updown_param
// Description : Parametrised up/down counter with up, down, ping-pong and
//               stop modes, count enable, a one-cycle terminal-count pulse
//               and optional saturation at the limits.
//               Build macro CONTADOR_CARGA_EN adds the parallel-load ports
//               (i_carga, i_valor_carga) and their logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module contador_updown_param #(
  parameter int WIDTH      = 4,
  parameter int LIMITE_MIN = 0,
  parameter int LIMITE_MAX = 2**WIDTH-1,
  parameter bit SATURA     = 1'b0
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_habilita,
  input  logic [1:0]       i_modo,
`ifdef CONTADOR_CARGA_EN
  input  logic             i_carga,
  input  logic [WIDTH-1:0] i_valor_carga,
`endif
  output logic [WIDTH-1:0] o_saida,
  output logic             o_direcao,
  output logic             o_fim
);

  localparam logic [WIDTH-1:0] c_MIN = WIDTH'(LIMITE_MIN);
  localparam logic [WIDTH-1:0] c_MAX = WIDTH'(LIMITE_MAX);

  localparam logic [1:0] c_MODO_CRESC  = 2'b00;
  localparam logic [1:0] c_MODO_DECRES = 2'b01;
  localparam logic [1:0] c_MODO_VAIVEM = 2'b10;
  localparam logic [1:0] c_MODO_PARADO = 2'b11;

  logic [WIDTH-1:0] r_saida;
  logic             r_direcao;
  logic             r_fim;

  logic [WIDTH-1:0] w_next_saida;
  logic             w_next_direcao;
  logic             w_next_fim;

  logic             w_pp_sobe;
  logic [WIDTH-1:0] w_pp_alvo;

`ifdef CONTADOR_CARGA_EN
  logic [WIDTH:0]   w_dif_min;
  logic [WIDTH:0]   w_dif_max;
  logic [WIDTH-1:0] w_carga_sat;

  // Clamp the load value into [LIMITE_MIN, LIMITE_MAX]; borrow bits give the
  // out-of-range tests without comparing against constant bounds.
  always_comb begin
    w_dif_min   = {1'b0, i_valor_carga} - {1'b0, c_MIN};
    w_dif_max   = {1'b0, c_MAX} - {1'b0, i_valor_carga};
    w_carga_sat = i_valor_carga;
    if (w_dif_min[WIDTH]) begin
      w_carga_sat = c_MIN;
    end else if (w_dif_max[WIDTH]) begin
      w_carga_sat = c_MAX;
    end
  end
`endif

  // Ping-pong step: keep the current direction unless already sitting on the
  // limit it points at, in which case reverse instead of overflowing.
  always_comb begin
    w_pp_sobe = r_direcao ? (r_saida != c_MAX) : (r_saida == c_MIN);
    w_pp_alvo = w_pp_sobe ? (r_saida + 1'b1) : (r_saida - 1'b1);
  end

  // Next-state selection in priority order: load, enable, mode step.
  always_comb begin
    w_next_saida   = r_saida;
    w_next_direcao = r_direcao;
    w_next_fim     = 1'b0;
`ifdef CONTADOR_CARGA_EN
    if (i_carga) begin
      w_next_saida = w_carga_sat;
      if (i_modo == c_MODO_VAIVEM) begin
        if (w_carga_sat == c_MAX) begin
          w_next_direcao = 1'b0;
        end else if (w_carga_sat == c_MIN) begin
          w_next_direcao = 1'b1;
        end
      end
    end else
`endif
    if (i_habilita) begin
      case (i_modo)
        c_MODO_CRESC: begin
          w_next_direcao = 1'b1;
          if (r_saida != c_MAX) begin
            w_next_saida = r_saida + 1'b1;
            w_next_fim   = ((r_saida + 1'b1) == c_MAX);
          end else if (!SATURA) begin
            // Wrap to the opposite limit; not a terminal-count event.
            w_next_saida = c_MIN;
          end
        end
        c_MODO_DECRES: begin
          w_next_direcao = 1'b0;
          if (r_saida != c_MIN) begin
            w_next_saida = r_saida - 1'b1;
            w_next_fim   = ((r_saida - 1'b1) == c_MIN);
          end else if (!SATURA) begin
            w_next_saida = c_MAX;
          end
        end
        c_MODO_VAIVEM: begin
          w_next_saida = w_pp_alvo;
          if (w_pp_alvo == c_MAX) begin
            w_next_direcao = 1'b0;
            w_next_fim     = 1'b1;
          end else if (w_pp_alvo == c_MIN) begin
            w_next_direcao = 1'b1;
            w_next_fim     = 1'b1;
          end else begin
            w_next_direcao = w_pp_sobe;
          end
        end
        c_MODO_PARADO: begin
          w_next_saida   = r_saida;
          w_next_direcao = r_direcao;
        end
        default: begin
          w_next_saida   = r_saida;
          w_next_direcao = r_direcao;
        end
      endcase
    end
  end

  // State register with asynchronous reset to the lower limit, counting up.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_saida   <= c_MIN;
      r_direcao <= 1'b1;
      r_fim     <= 1'b0;
    end else begin
      r_saida   <= w_next_saida;
      r_direcao <= w_next_direcao;
      r_fim     <= w_next_fim;
    end
  end

  assign o_saida   = r_saida;
  assign o_direcao = r_direcao;
  assign o_fim     = r_fim;

endmodule

`default_nettype wire

// File: tb/tb_contador_updown_param.sv
// ============================================================================
// Module      : tb_contador_updown_param
// Description : Self-checking bench for contador_updown_param. Stimulus pushes
//               expected outputs into a queue; a monitor pops and compares.
//               Load tests are built only with CONTADOR_CARGA_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_contador_updown_param;

  typedef struct {
    int         id;
    string      nm;
    logic [3:0] s;
    logic       d;
    logic       f;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       habilita = 1'b0;
  logic [1:0] modo = 2'b11;
  logic       carga = 1'b0;
  logic [3:0] valor_carga = 4'd0;

  logic [3:0] saida_a, saida_b, saida_c;
  logic       dir_a, dir_b, dir_c;
  logic       fim_a, fim_b, fim_c;
`ifdef CONTADOR_CARGA_EN
  logic [3:0] saida_d;
  logic       dir_d, fim_d;
`endif

  exp_t sb[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_err = 0;

  int pp_s[9] = '{3, 4, 5, 6, 5, 4, 3, 2, 3};
  int pp_d[9] = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
  int pp_f[9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};

  always #5 clk = ~clk;

  // Defaults: 0..15, wrapping
  contador_updown_param u_a (
    .i_clock(clk), .i_reset(reset), .i_habilita(habilita), .i_modo(modo),
`ifdef CONTADOR_CARGA_EN
    .i_carga(carga), .i_valor_carga(valor_carga),
`endif
    .o_saida(saida_a), .o_direcao(dir_a), .o_fim(fim_a)
  );

  // Ping-pong range 2..6
  contador_updown_param #(.WIDTH(4), .LIMITE_MIN(2), .LIMITE_MAX(6)) u_b (
    .i_clock(clk), .i_reset(reset), .i_habilita(habilita), .i_modo(modo),
`ifdef CONTADOR_CARGA_EN
    .i_carga(carga), .i_valor_carga(valor_carga),
`endif
    .o_saida(saida_b), .o_direcao(dir_b), .o_fim(fim_b)
  );

  // Saturating 0..15
  contador_updown_param #(.WIDTH(4), .SATURA(1'b1)) u_c (
    .i_clock(clk), .i_reset(reset), .i_habilita(habilita), .i_modo(modo),
`ifdef CONTADOR_CARGA_EN
    .i_carga(carga), .i_valor_carga(valor_carga),
`endif
    .o_saida(saida_c), .o_direcao(dir_c), .o_fim(fim_c)
  );

`ifdef CONTADOR_CARGA_EN
  // Load tests, range 0..12
  contador_updown_param #(.WIDTH(4), .LIMITE_MAX(12)) u_d (
    .i_clock(clk), .i_reset(reset), .i_habilita(habilita), .i_modo(modo),
    .i_carga(carga), .i_valor_carga(valor_carga),
    .o_saida(saida_d), .o_direcao(dir_d), .o_fim(fim_d)
  );
`endif

  task automatic cmp(input string nm, input string fld, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s.%s: got %0d, required %0d (t=%0t)", nm, fld, act, req, $time);
    end
  endtask

  task automatic push(input int id, input string nm, input int es, input logic ed, input logic ef);
    exp_t e;
    e.id = id;
    e.nm = nm;
    e.s  = 4'(es);
    e.d  = ed;
    e.f  = ef;
    sb.push_back(e);
  endtask

  // Monitor: after each rising edge (or an asynchronous check request),
  // compare the selected instance against every queued expectation.
  initial begin
    exp_t       e;
    logic [3:0] as;
    logic       ad, af;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        as = 4'hx; ad = 1'bx; af = 1'bx;
        case (e.id)
          0: begin as = saida_a; ad = dir_a; af = fim_a; end
          1: begin as = saida_b; ad = dir_b; af = fim_b; end
          2: begin as = saida_c; ad = dir_c; af = fim_c; end
`ifdef CONTADOR_CARGA_EN
          3: begin as = saida_d; ad = dir_d; af = fim_d; end
`endif
          default: ;
        endcase
        cmp(e.nm, "saida",   (^as === 1'bx) ? -1 : int'(as), int'(e.s));
        cmp(e.nm, "direcao", (ad === 1'bx) ? -1 : int'(ad), int'(e.d));
        cmp(e.nm, "fim",     (af === 1'bx) ? -1 : int'(af), int'(e.f));
      end
    end
  end

  // Callers start at a falling edge; one counting edge per call.
  task automatic step(input int id, input string nm, input logic h, input logic [1:0] m,
                      input int es, input logic ed, input logic ef);
    habilita = h;
    modo     = m;
    carga    = 1'b0;
    push(id, nm, es, ed, ef);
    @(negedge clk);
  endtask

  task automatic load(input int id, input string nm, input logic h, input logic [1:0] m,
                      input int v, input int es, input logic ed, input logic ef);
    habilita    = h;
    modo        = m;
    carga       = 1'b1;
    valor_carga = 4'(v);
    push(id, nm, es, ed, ef);
    @(negedge clk);
    carga = 1'b0;
  endtask

  // Assert reset between edges and check outputs before the next edge,
  // then again after an edge with reset still held.
  task automatic rst_check(input int id, input string nm, input int es);
    reset    = 1'b1;
    habilita = 1'b1;
    modo     = 2'b00;
    carga    = 1'b0;
    #1;
    push(id, nm, es, 1'b1, 1'b0);
    ->chk_ev;
    #2;
    push(id, {nm, "_held"}, es, 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    @(negedge clk);

    // Up counting with wrap on defaults
    rst_check(0, "rst_a", 0);
    for (int i = 1; i <= 16; i++) step(0, "inc_wrap", 1'b1, 2'b00, i % 16, 1'b1, i == 15);

    // Reset in the middle of a count
    for (int i = 1; i <= 7; i++) step(0, "inc7", 1'b1, 2'b00, i, 1'b1, 1'b0);
    rst_check(0, "rst_mid", 0);
    step(0, "post_rst", 1'b1, 2'b00, 1, 1'b1, 1'b0);

    // Enable off and stop mode hold
    for (int i = 2; i <= 4; i++) step(0, "inc_to4", 1'b1, 2'b00, i, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(0, "hab0", 1'b0, 2'b00, 4, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(0, "modo11", 1'b1, 2'b11, 4, 1'b1, 1'b0);
    step(0, "resume", 1'b1, 2'b00, 5, 1'b1, 1'b0);

    // Reach the top, then ping-pong reverses instead of overflowing
    for (int i = 6; i <= 15; i++) step(0, "inc_top", 1'b1, 2'b00, i, 1'b1, i == 15);
    step(0, "pp_rev",  1'b1, 2'b10, 14, 1'b0, 1'b0);
    step(0, "pp_down", 1'b1, 2'b10, 13, 1'b0, 1'b0);
    step(0, "dec",     1'b1, 2'b01, 12, 1'b0, 1'b0);

    // Down wrap from the lower limit
    rst_check(0, "rst_a2", 0);
    step(0, "dec_wrap", 1'b1, 2'b01, 15, 1'b0, 1'b0);
    step(0, "dec_14",   1'b1, 2'b01, 14, 1'b0, 1'b0);

    // Ping-pong 2..6
    rst_check(1, "rst_b", 2);
    for (int i = 0; i < 9; i++)
      step(1, "pingpong", 1'b1, 2'b10, pp_s[i], pp_d[i] != 0, pp_f[i] != 0);

    // Saturation
    rst_check(2, "rst_c", 0);
    step(2, "sat_lo0", 1'b1, 2'b01, 0, 1'b0, 1'b0);
    step(2, "up1",     1'b1, 2'b00, 1, 1'b1, 1'b0);
    step(2, "up2",     1'b1, 2'b00, 2, 1'b1, 1'b0);
    step(2, "sat_1",   1'b1, 2'b01, 1, 1'b0, 1'b0);
    step(2, "sat_0",   1'b1, 2'b01, 0, 1'b0, 1'b1);
    step(2, "sat_h1",  1'b1, 2'b01, 0, 1'b0, 1'b0);
    step(2, "sat_h2",  1'b1, 2'b01, 0, 1'b0, 1'b0);

`ifdef CONTADOR_CARGA_EN
    // Parallel load on 0..12
    rst_check(3, "rst_d", 0);
    load(3, "ld9",     1'b0, 2'b00, 9,  9,  1'b1, 1'b0);
    load(3, "ld15",    1'b0, 2'b00, 15, 12, 1'b1, 1'b0);
    step(3, "wrap12",  1'b1, 2'b00, 0,  1'b1, 1'b0);
    load(3, "ld_step", 1'b1, 2'b00, 5,  5,  1'b1, 1'b0);
    load(3, "ld_pmax", 1'b1, 2'b10, 12, 12, 1'b0, 1'b0);
    step(3, "pp_11",   1'b1, 2'b10, 11, 1'b0, 1'b0);
    load(3, "ld_pmin", 1'b1, 2'b10, 0,  0,  1'b1, 1'b0);
    step(3, "pp_1",    1'b1, 2'b10, 1,  1'b1, 1'b0);
`endif

    habilita = 1'b0;
    @(negedge clk);
    if (sb.size() != 0) cmp("queue", "leftover", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/contador_updown_param.md
# contador_updown_param

Parametrised up/down counter: the next generation of the fixed 4-bit ascending/descending counter. It adds configurable width and limits, four counting modes including ping-pong, count enable, a terminal-count pulse, a saturation option and optional parallel load. It drives sequence/address generation in the datapath and test benches, and replaces the fixed 4-bit counter wherever a different range or mode is needed.

## Interface
- WIDTH, 4, counter width in bits (≥2)
- LIMITE_MIN, 0, lowest count value
- LIMITE_MAX, 2**WIDTH-1, highest count value; LIMITE_MIN < LIMITE_MAX ≤ 2**WIDTH-1
- SATURA, 0, 0 = wrap at limit in modes 00/01, 1 = hold at limit
- clock  in  1  single clock, rising-edge active
- reset  in  1  asynchronous, active-high reset
- habilita  in  1  count enable
- modo  in  2  00 crescente, 01 decrescente, 10 vai-e-volta (ping-pong), 11 parado
- carga  in  1  parallel load strobe (only with CONTADOR_CARGA_EN)
- valor_carga  in  WIDTH  load value (only with CONTADOR_CARGA_EN)
- saida  out  WIDTH  current count
- direcao  out  1  1 = counting up, 0 = counting down
- fim  out  1  one-cycle terminal-count pulse

## Operation
- Reset, while asserted and independent of clock: saida=LIMITE_MIN, direcao=1, fim=0.
- Per rising edge, priority order:
  - reset
  - carga
  - habilita=0 (hold)
  - modo step
- carga:
  - saida ← valor_carga clamped to [LIMITE_MIN, LIMITE_MAX].
  - Acts even when habilita=0.
  - fim ← 0.
  - In ping-pong: loading LIMITE_MAX sets direcao=0 and loading LIMITE_MIN sets direcao=1. Otherwise direcao is unchanged.
- habilita=0: saida and direcao hold; fim ← 0.
- modo 00: direcao ← 1.
  - saida < LIMITE_MAX: saida+1.
  - At LIMITE_MAX: wrap to LIMITE_MIN (SATURA=0) or hold (SATURA=1).
- modo 01: direcao ← 0.
  - saida > LIMITE_MIN: saida−1.
  - At LIMITE_MIN: wrap to LIMITE_MAX (SATURA=0) or hold (SATURA=1).
- modo 10 (ping-pong): steps in the direction given by direcao.
  - The step that lands on LIMITE_MAX sets direcao=0. The step that lands on LIMITE_MIN sets direcao=1.
  - Each endpoint appears for exactly one cycle. Period is 2·(LIMITE_MAX−LIMITE_MIN) enabled edges.
  - SATURA is ignored.
- modo 11: saida and direcao hold; fim ← 0.
- fim ← 1 only on an edge where a counting step changes saida to the terminal value of the active mode:
  - modo 00: LIMITE_MAX
  - modo 01: LIMITE_MIN
  - modo 10: either endpoint
  - A wrap to the opposite limit does not raise fim. A saturated hold does not raise fim.
- Mode change takes effect at the next edge, from the current saida. Ping-pong keeps the existing direcao.
  - If saida already equals the limit it is heading toward, the ping-pong step reverses instead of overflowing: at LIMITE_MAX with direcao=1, the next value is LIMITE_MAX−1 and direcao=0.
- Arithmetic is WIDTH-bit unsigned. saida never leaves [LIMITE_MIN, LIMITE_MAX].

## Timing
- All outputs are registered. Latency from habilita/modo/carga to saida is 1 edge.
- fim is valid in the same cycle saida first shows the terminal value. It is low the next cycle unless another qualifying step occurs.
- Reset assertion clears the outputs immediately, mid-count included. The first step is taken on the first rising edge after deassertion.
- carga and a counting step in the same cycle: the load wins and no step is taken.

## Configuration
- CONTADOR_CARGA_EN defined: carga and valor_carga ports exist, with load behaviour as above.
- Not defined: both ports and all load logic are compiled out. The counter only resets, holds and counts.

## Test plan
- Reset mid-count: modo=00, counting at saida=7; raise reset between edges → saida=0, direcao=1, fim=0 before the next edge. After release, the first edge gives 1.
- Crescente wrap (defaults): modo=00, habilita=1, 16 edges from 0 → 1…15, 0. fim is high only while saida=15.
- Ping-pong with LIMITE_MIN=2, LIMITE_MAX=6: edges from 2 → 3,4,5,6,5,4,3,2,3. direcao falls at 6 and rises at 2. fim is high at 6 and at the second 2.
- Saturation: SATURA=1, modo=01, loaded 2 → 1, 0, 0, 0. fim pulses once, at the first 0.
- Load (CONTADOR_CARGA_EN, LIMITE_MAX=12):
  - carga=1, valor_carga=9, habilita=0 → saida=9.
  - valor_carga=15 → saida=12.
  - carga together with habilita=1, modo=00 → loaded value, with no increment.
- Enable/hold: habilita=0 or modo=11 for 5 edges at saida=4 → saida stays 4, fim=0. Restoring habilita=1, modo=00 → 5 on the next edge.
